// File: rtl/ipg_rx_buffered_if.sv
// Job FIFO consumer interface for ipg_rx_buffered.
// master: drives job_data/job_valid/job_level; slave: drives job_ready.
interface ipg_rx_buffered_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [55:0]   job_data;
    logic          job_valid;
    logic          job_ready;
    logic [LW-1:0] job_level;

    modport master (
        output job_data,
        output job_valid,
        output job_level,
        input  job_ready
    );

    modport slave (
        input  job_data,
        input  job_valid,
        input  job_level,
        output job_ready
    );
endinterface

// File: rtl/ipg_rx_buffered.sv
// IPG RX extractor: strips REQ/RESP control blocks, queues REQ jobs, latches RESP.
// Ports: clk/rst_n, ipg_en, encoded_rx_*, rec_rx_*, shimq_write, job_if (master),
// ipg_resp/_valid, ovf_sticky, req/resp/drop_cnt (built only with IPG_RX_STATS_EN).
module ipg_rx_buffered #(
    parameter int         FIFO_DEPTH = 8,
    parameter int         CNT_WIDTH  = 16,
    parameter logic [7:0] BT_REQ     = 8'h1a,
    parameter logic [7:0] BT_RESP    = 8'h1f,
    parameter logic [7:0] BT_IDLE    = 8'h1e
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ipg_en,
    input  logic [1:0]           encoded_rx_hdr,
    input  logic [63:0]          encoded_rx_data,
    output logic [1:0]           rec_rx_hdr,
    output logic [63:0]          rec_rx_data,
    output logic                 shimq_write,
    ipg_rx_buffered_if.master    job_if,
    output logic [63:0]          ipg_resp,
    output logic                 ipg_resp_valid,
    output logic                 ovf_sticky,
    output logic [CNT_WIDTH-1:0] req_cnt,
    output logic [CNT_WIDTH-1:0] resp_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [7:0]    blk_type;
    logic          is_ctrl;
    logic          is_req;
    logic          is_resp;
    logic          full;
    logic          pop;
    logic          push_acc;
    logic          drop;

    logic [1:0]    hdr_q;
    logic [63:0]   data_q, data_d;
    logic          shim_q, shim_d;
    logic [63:0]   resp_q, resp_d;
    logic          resp_v_q;
    logic          ovf_q;

    logic [55:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        blk_type = encoded_rx_data[7:0];
        is_ctrl  = (encoded_rx_hdr == 2'b01);
        is_req   = ipg_en && is_ctrl && (blk_type == BT_REQ);
        is_resp  = ipg_en && is_ctrl && (blk_type == BT_RESP);
        full     = (level_q == FULL_LVL);
        pop      = (level_q != '0) && job_if.job_ready;
        // A full FIFO still accepts a push when the head leaves this cycle.
        push_acc = is_req && (!full || pop);
        drop     = is_req && full && !pop;
        level_d  = level_q + LW'(push_acc) - LW'(pop);
        data_d   = (is_req || is_resp) ? {56'h0, BT_IDLE}
                                       : encoded_rx_data;
        // Start/term/ordered-set ctrl types sort above idle.
        shim_d   = !is_ctrl ||
                   ((blk_type > BT_IDLE) && !is_req && !is_resp);
        resp_d   = is_resp ? encoded_rx_data : resp_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_q    <= '0;
            data_q   <= '0;
            shim_q   <= 1'b0;
            resp_q   <= '0;
            resp_v_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            hdr_q    <= encoded_rx_hdr;
            data_q   <= data_d;
            shim_q   <= shim_d;
            resp_q   <= resp_d;
            resp_v_q <= is_resp;
            ovf_q    <= ovf_q || drop;
            level_q  <= level_d;
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: reads are gated by the occupancy.
    always_ff @(posedge clk) begin
        if (rst_n && push_acc) mem_q[wr_ptr_q] <= encoded_rx_data[63:8];
    end

    assign rec_rx_hdr       = hdr_q;
    assign rec_rx_data      = data_q;
    assign shimq_write      = shim_q;
    assign ipg_resp         = resp_q;
    assign ipg_resp_valid   = resp_v_q;
    assign ovf_sticky       = ovf_q;
    assign job_if.job_valid = (level_q != '0);
    assign job_if.job_level = level_q;
    assign job_if.job_data  = job_if.job_valid ? mem_q[rd_ptr_q] : '0;

`ifdef IPG_RX_STATS_EN
    logic [CNT_WIDTH-1:0] req_cnt_q, resp_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push_acc && (req_cnt_q != '1))
                req_cnt_q <= req_cnt_q + 1'b1;
            if (is_resp && (resp_cnt_q != '1))
                resp_cnt_q <= resp_cnt_q + 1'b1;
            if (drop && (drop_cnt_q != '1))
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign req_cnt  = req_cnt_q;
    assign resp_cnt = resp_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign req_cnt  = '0;
    assign resp_cnt = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_ipg_rx_buffered.sv
// Randomized self-checking bench for ipg_rx_buffered.
// Reference model: a payload queue plus expected-output variables.
module tb_ipg_rx_buffered;
    localparam int D  = 8;
    localparam int CW = 16;
    localparam int LW = $clog2(D) + 1;

    logic          clk;
    logic          rst_n;
    logic          ipg_en;
    logic [1:0]    hdr;
    logic [63:0]   data;
    logic [1:0]    rec_hdr;
    logic [63:0]   rec_data;
    logic          shim;
    logic [63:0]   resp;
    logic          resp_v;
    logic          ovf;
    logic [CW-1:0] rcnt, scnt, dcnt;

    ipg_rx_buffered_if #(.FIFO_DEPTH(D)) jif ();

    ipg_rx_buffered #(.FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ipg_en          (ipg_en),
        .encoded_rx_hdr  (hdr),
        .encoded_rx_data (data),
        .rec_rx_hdr      (rec_hdr),
        .rec_rx_data     (rec_data),
        .shimq_write     (shim),
        .job_if          (jif.master),
        .ipg_resp        (resp),
        .ipg_resp_valid  (resp_v),
        .ovf_sticky      (ovf),
        .req_cnt         (rcnt),
        .resp_cnt        (scnt),
        .drop_cnt        (dcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [55:0] mq[$];
    logic [1:0]  e_hdr;
    logic [63:0] e_data, e_resp;
    logic        e_shim, e_rv, e_ovf, e_rst;
    int          m_req, m_resp, m_drop;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic step(input logic rn, input logic en,
                        input logic [1:0] h, input logic [63:0] d,
                        input logic rdy);
        logic ctrl, req, rsp;
        @(negedge clk);
        rst_n = rn;
        ipg_en = en;
        hdr = h;
        data = d;
        jif.job_ready = rdy;
        e_rst = !rn;
        if (!rn) begin
            mq.delete();
            e_hdr = '0; e_data = '0; e_shim = 0; e_rv = 0;
            e_resp = '0; e_ovf = 0;
            m_req = 0; m_resp = 0; m_drop = 0;
        end else begin
            ctrl = (h == 2'b01);
            req = en && ctrl && (d[7:0] == 8'h1a);
            rsp = en && ctrl && (d[7:0] == 8'h1f);
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (req) begin
                if (mq.size() < D) begin
                    mq.push_back(d[63:8]);
                    m_req = sat(m_req);
                end else begin
                    e_ovf = 1;
                    m_drop = sat(m_drop);
                end
            end
            if (rsp) begin
                e_resp = d;
                m_resp = sat(m_resp);
            end
            e_rv = rsp;
            e_hdr = h;
            e_data = (req || rsp) ? 64'h1e : d;
            e_shim = !ctrl || (d[7:0] > 8'h1e && !req && !rsp);
        end
        @(posedge clk);
        #1;
        check("rec_hdr", 64'(rec_hdr), 64'(e_hdr));
        check("rec_data", rec_data, e_data);
        check("shimq_write", 64'(shim), 64'(e_shim));
        check("resp_valid", 64'(resp_v), 64'(e_rv));
        check("ipg_resp", resp, e_resp);
        check("ovf_sticky", 64'(ovf), 64'(e_ovf));
        check("job_valid", 64'(jif.job_valid), 64'(mq.size() > 0));
        check("job_level", 64'(jif.job_level), 64'(mq.size()));
        if (mq.size() > 0)
            check("job_data", 64'(jif.job_data), 64'(mq[0]));
        else if (e_rst)
            check("job_data_rst", 64'(jif.job_data), 64'h0);
`ifdef IPG_RX_STATS_EN
        check("req_cnt", 64'(rcnt), 64'(m_req));
        check("resp_cnt", 64'(scnt), 64'(m_resp));
        check("drop_cnt", 64'(dcnt), 64'(m_drop));
`else
        check("req_cnt", 64'(rcnt), 64'h0);
        check("resp_cnt", 64'(scnt), 64'h0);
        check("drop_cnt", 64'(dcnt), 64'h0);
`endif
    endtask

    function automatic logic [63:0] rnd_blk();
        logic [63:0] v;
        logic [7:0]  t;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0, 1:    t = 8'h1a;
            2:       t = 8'h1f;
            3:       t = 8'h1e;
            4:       t = 8'h00;
            5:       t = 8'hb4;
            default: t = 8'($urandom);
        endcase
        v[7:0] = t;
        return v;
    endfunction

    function automatic logic [1:0] rnd_hdr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 2'b01;
        if (r < 9) return 2'b10;
        return 2'($urandom);
    endfunction

    initial begin
        rst_n = 0; ipg_en = 0; hdr = 0; data = 0; jif.job_ready = 0;
        e_ovf = 0; e_resp = 0;
        step(0, 0, 2'b00, 64'h0, 0);
        step(0, 0, 2'b00, 64'h0, 0);
        // single REQ then single RESP
        step(1, 1, 2'b01, 64'h11223344556677_1a, 0);
        step(1, 1, 2'b01, 64'habcd0123456789_1f, 0);
        step(1, 1, 2'b10, 64'h0, 0);
        // fill, overflow, then pop+push while full
        step(0, 1, 2'b00, 64'h0, 0);
        for (int i = 0; i < 9; i++)
            step(1, 1, 2'b01, {56'(i + 1) << 4, 8'h1a}, 0);
        step(1, 1, 2'b01, {56'hface, 8'h1a}, 1);
        // block type classification
        step(1, 1, 2'b10, 64'h0123456789abcdef, 0);
        step(1, 1, 2'b01, 64'h00000000000000b4, 0);
        step(1, 1, 2'b01, 64'h000000000000001e, 0);
        step(1, 1, 2'b01, 64'h5555555555555500, 0);
        // transparent mode
        step(1, 0, 2'b01, 64'h11223344556677_1a, 0);
        step(1, 0, 2'b01, 64'habcd0123456789_1f, 0);
        // drain, then reset with jobs and RESP in flight
        for (int i = 0; i < 10; i++) step(1, 1, 2'b10, 64'h0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 1, 2'b01, {56'(i + 7), 8'h1a}, 0);
        step(1, 1, 2'b01, 64'h77_1f, 0);
        step(0, 1, 2'b01, 64'h88_1f, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                 rnd_hdr(), rnd_blk(), $urandom_range(0, 9) < 3);
`ifdef IPG_RX_STATS_EN
        step(0, 1, 2'b00, 64'h0, 0);
        for (int i = 0; i < 65540; i++)
            step(1, 1, 2'b01, {56'(i), 8'h1a}, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
